// File: rtl/cic_comp_pkg.sv
// rtl/cic_comp_pkg.sv - shared constants, types and coefficients for the CIC compensation FIR
package cic_comp_pkg;

  localparam int NTAPS  = 8;
  localparam int COEF_W = 16;
  localparam int SHIFT  = 15;
  localparam int PTR_W  = $clog2(NTAPS);

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND
  } fsm_e;

  // Symmetric droop-compensation taps; they sum to 2^SHIFT for unity DC gain.
  localparam coef_t COEF [0:NTAPS-1] = '{
    -16'sd410, 16'sd1229, -16'sd3277, 16'sd18842,
    16'sd18842, -16'sd3277, 16'sd1229, -16'sd410
  };

  function automatic coef_t coef_at(input logic [PTR_W-1:0] tap);
    return COEF[tap];
  endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// rtl/cic_comp_fir_if.sv - sample input, result output and status signals of the compensation FIR
interface cic_comp_fir_if #(
  parameter int DATA_W = 25,
  parameter int OUT_W  = 25
);

  logic signed [DATA_W-1:0] din;
  logic                     din_valid;
  logic signed [OUT_W-1:0]  dout;
  logic                     dout_valid;
  logic                     dout_ready;
  logic                     overrun;
  logic                     clr_overrun;
  logic                     busy;

  modport master (
    output din, din_valid, dout_ready, clr_overrun,
    input  dout, dout_valid, overrun, busy
  );

  modport slave (
    input  din, din_valid, dout_ready, clr_overrun,
    output dout, dout_valid, overrun, busy
  );

endinterface

// File: rtl/cic_comp_mac.sv
// rtl/cic_comp_mac.sv - registered MAC with clear/enable and round, saturate (CIC_COMP_SAT_EN) or wrap output
module cic_comp_mac
  import cic_comp_pkg::*;
#(
  parameter int DATA_W = 25,
  parameter int OUT_W  = 25,
  parameter int ACC_W  = DATA_W + COEF_W + 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  coef_t                    coef,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [OUT_W-1:0]  result
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RND_W  = ACC_W - SHIFT;
  localparam logic signed [ACC_W-1:0] HALF =
    {{(ACC_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [RND_W-1:0]  rnd;

  assign prod     = sample * coef;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

  // Round half up, then keep the integer part as the arithmetic-shifted value.
  assign rounded = acc + HALF;
  assign rnd     = rounded[ACC_W-1:SHIFT];

`ifdef CIC_COMP_SAT_EN
  localparam logic signed [RND_W-1:0] MAXV =
    {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] MINV =
    {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic unused_frac;
  assign unused_frac = ^rounded[SHIFT-1:0];

  always_comb begin
    result = rnd[OUT_W-1:0];
    if (rnd > MAXV) begin
      result = MAXV[OUT_W-1:0];
    end else if (rnd < MINV) begin
      result = MINV[OUT_W-1:0];
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{rounded[SHIFT-1:0], rnd[RND_W-1:OUT_W]};
  assign result      = rnd[OUT_W-1:0];
`endif

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - 8-tap serial-MAC CIC droop compensation FIR; CIC_COMP_SAT_EN selects output saturation
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DATA_W = 25,
  parameter int OUT_W  = 25
) (
  input  logic           clk,
  input  logic           reset,
  cic_comp_fir_if.slave  bus
);

  fsm_e                     state;
  fsm_e                     state_nxt;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         tap;
  logic [PTR_W-1:0]         rd_idx;
  logic signed [DATA_W-1:0] sbuf [0:NTAPS-1];
  logic signed [OUT_W-1:0]  dout_q;
  logic signed [OUT_W-1:0]  result;
  logic                     dout_valid_q;
  logic                     overrun_q;

  logic accept;
  logic mac_en;
  logic round;
  logic load;
  logic discard;
  logic drop_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mac_en    = 1'b0;
    round     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.din_valid) begin
          accept    = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap == PTR_W'(NTAPS-1)) begin
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        round     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign drop_in = bus.din_valid && (state != IDLE);
  assign load    = round && (!dout_valid_q || bus.dout_ready);
  assign discard = round && !load;

  // wr_ptr already points past the newest sample; NTAPS is a power of two so
  // the pointer arithmetic wraps modulo the buffer depth.
  assign rd_idx = wr_ptr - PTR_W'(1) - tap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      tap    <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        sbuf[i] <= '0;
      end
    end else begin
      if (accept) begin
        sbuf[wr_ptr] <= bus.din;
        wr_ptr       <= wr_ptr + PTR_W'(1);
        tap          <= '0;
      end else if (mac_en) begin
        tap <= tap + PTR_W'(1);
      end
    end
  end

  cic_comp_mac #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (mac_en),
    .coef   (coef_at(tap)),
    .sample (sbuf[rd_idx]),
    .result (result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (load) begin
      dout_q       <= result;
      dout_valid_q <= 1'b1;
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear wins so no loss goes unreported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (drop_in || discard) begin
      overrun_q <= 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != IDLE);

endmodule
